// File: rtl/div_seq.sv
// div_seq: sequential restoring unsigned divider with valid/ready handshake on both sides
module div_seq #(
  parameter int SIZE = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SIZE-1:0] dividend,
  input  logic [SIZE-1:0] divisor,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [SIZE-1:0] quot,
  output logic [SIZE-1:0] rem,
  output logic            div_by_zero,
  output logic            out_valid,
  input  logic            out_ready
);
  localparam int CW = $clog2(SIZE);
  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [SIZE-1:0] dvs, prem, prem_nx, dvq, dvq_nx;
  logic [SIZE:0] prem_sh, diff;
  logic take, last;
  // one restoring step; dvq shifts dividend bits out the top while quotient bits enter at the bottom
  always_comb begin
    take = in_valid && in_ready;
    last = state == BUSY && cnt == '0;
    prem_sh = {prem, dvq[SIZE-1]};
    diff = prem_sh - {1'b0, dvs};
    prem_nx = diff[SIZE] ? prem_sh[SIZE-1:0] : diff[SIZE-1:0];
    dvq_nx = {dvq[SIZE-2:0], ~diff[SIZE]};
    state_nx = (state == IDLE && take) ? BUSY :
               last ? DONE :
               (state == DONE && out_ready) ? IDLE : state;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // operand capture, iteration datapath and registered handshake/result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      dvs <= '0;
      prem <= '0;
      dvq <= '0;
      quot <= '0;
      rem <= '0;
      div_by_zero <= 1'b0;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      if (take) begin
        cnt <= LAST;
        dvs <= divisor;
        prem <= '0;
        dvq <= dividend;
      end else if (state == BUSY) begin
        cnt <= cnt - 1'b1;
        prem <= prem_nx;
        dvq <= dvq_nx;
      end
      if (last) begin
        quot <= dvq_nx;
        rem <= prem_nx;
        div_by_zero <= dvs == '0;
      end
      in_ready <= state_nx == IDLE;
      out_valid <= state_nx == DONE;
    end
  end
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: scoreboard bench for div_seq with directed corner cases and randomized operations
module tb_div_seq;
  localparam int N = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic in_ready, div_by_zero, out_valid;
  logic [N-1:0] quot, rem;
  int checks = 0;
  int errors = 0;
  bit rand_ready = 1'b0;
  logic [2*N:0] exp_q[$];
  longint t_q[$];
  logic prev_ov = 1'b0;
  logic [2*N:0] held, exp_v;
  longint t_acc, t_now;

  always #5 clk = ~clk;

  div_seq #(.SIZE(N)) dut (
    .clk(clk), .rst_n(rst_n), .dividend(dividend), .divisor(divisor),
    .in_valid(in_valid), .in_ready(in_ready), .quot(quot), .rem(rem),
    .div_by_zero(div_by_zero), .out_valid(out_valid), .out_ready(out_ready)
  );

  function automatic logic [2*N:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
    return (b == 0) ? {{N{1'b1}}, a, 1'b1} : {a / b, a % b, 1'b0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: pops the scoreboard on each new result, checks latency, hold stability and in_ready
  always @(negedge clk) begin
    if (!rst_n) prev_ov = 1'b0;
    else begin
      if (out_valid) begin
        check("in_ready_low_in_done", in_ready, 0);
        if (!prev_ov) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out_valid: got quot=%0h rem=%0h expected no result", quot, rem);
          end else begin
            exp_v = exp_q.pop_front();
            t_acc = t_q.pop_front();
            check("result", {quot, rem, div_by_zero}, exp_v);
            check("latency", $time - t_acc, N * 10 + 5);
          end
          held = {quot, rem, div_by_zero};
        end else check("hold_stable", {quot, rem, div_by_zero}, held);
      end
      prev_ov = out_valid;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // must be entered at a negedge; returns at a negedge just before the final iteration edge
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input bit noisy, output longint t);
    int k = 0;
    t = 0;
    while (!in_ready && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: got in_ready=0 expected 1");
      return;
    end
    in_valid = 1'b1;
    dividend = a;
    divisor = b;
    @(posedge clk);
    exp_q.push_back(model(a, b));
    t_q.push_back($time);
    t = $time;
    @(negedge clk);
    for (int i = 0; i < N - 1; i++) begin
      in_valid = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      dividend = N'($urandom);
      divisor = N'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_q.size() != 0 || out_valid) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0 || out_valid) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  initial begin
    logic [N-1:0] a, b;
    int sel;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_quot", quot, 0);
    check("rst_rem", rem, 0);
    check("rst_dbz", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    t_now = $time;
    issue(100, 7, 0, t_acc);
    check("first_accept_edge", t_acc - t_now, 5);
    issue(16'hFFFF, 1, 0, t_acc);
    issue(3, 10, 0, t_acc);
    issue(16'hFFFF, 16'hFFFF, 0, t_acc);
    issue(5, 0, 0, t_acc);
    issue(9, 3, 0, t_acc);
    drain();
    out_ready = 1'b0;
    issue(1234, 56, 0, t_acc);
    repeat (2) @(negedge clk);
    check("bp_out_valid", out_valid, 1);
    repeat (5) @(negedge clk);
    check("bp_still_valid", out_valid, 1);
    check("bp_in_ready", in_ready, 0);
    out_ready = 1'b1;
    @(negedge clk);
    check("release_out_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
    t_now = $time;
    issue(77, 7, 0, t_acc);
    check("accept_after_release", t_acc - t_now, 5);
    issue(50000, 123, 1, t_acc);
    issue(4321, 0, 1, t_acc);
    issue(65535, 256, 1, t_acc);
    drain();
    in_valid = 1'b1;
    dividend = 1000;
    divisor = 3;
    @(posedge clk);
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_quot", quot, 0);
    check("abort_rem", rem, 0);
    check("abort_dbz", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (N + 4) @(negedge clk);
    check("no_out_after_abort", out_valid, 0);
    issue(200, 9, 0, t_acc);
    drain();
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      a = N'($urandom);
      sel = $urandom_range(0, 3);
      b = (sel == 0) ? '0 : (sel == 1) ? N'($urandom_range(1, 15)) : (sel == 2) ? a : N'($urandom);
      issue(a, b, 1'($urandom_range(0, 1)), t_acc);
    end
    drain();
    rand_ready = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
